mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single DDR command path (the enter_state/outputs pair) between N_REQ client ports.
- Sequences one access at a time: selects a requester round-robin, presents its address, WE and write data, and holds DO_ACT until COMMAND_LATCHED.
- Tags each read so that the DATA_R word is returned to the correct client READ_LATENCY cycles after the latch.
- Also generates the toggling REFRESH_STROBE consumed by enter_state.

Parameters:
- N_REQ, 4: number of client ports, 2..8.
- READ_LATENCY, 4: cycles from the COMMAND_LATCHED cycle to a valid DATA_R.
- REFRESH_PERIOD, 1560: CLK cycles between REFRESH_STROBE toggles, at least 2.

Ports:
- CLK  in  1  controller clock, same clock as enter_state.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  N_REQ  per-client request pending.
- REQ_ADDR  in  27*N_REQ  client i address at bits [27i+26:27i].
- REQ_WE  in  N_REQ  1 = write, 0 = read.
- REQ_DATA  in  32*N_REQ  client i write data at [32i+31:32i].
- REQ_GRANT  out  N_REQ  one-hot pulse: the client's command was latched.
- RD_VALID  out  N_REQ  one-hot pulse: RD_DATA belongs to this client.
- RD_DATA  out  32  read data return, shared by all clients.
- ADDRESS_REQ  out  27  to enter_state.
- WE  out  1  to enter_state and outputs.
- DATA_W  out  32  to outputs.
- DO_ACT  out  1  to enter_state.
- COMMAND_LATCHED  in  1  from enter_state.
- DATA_R  in  32  from outputs.
- REFRESH_STROBE  out  1  toggle-type refresh request to enter_state.

Behaviour:
- Reset (asynchronous on RST high) forces:
  - DO_ACT=0, WE=0, ADDRESS_REQ=0, DATA_W=0.
  - REQ_GRANT=0, RD_VALID=0, RD_DATA=0, REFRESH_STROBE=0.
  - Round-robin pointer = N_REQ-1, so client 0 has first priority.
  - Read tag pipeline cleared; refresh counter = 0; FSM = IDLE.
- FSM states are IDLE and ISSUE.
- IDLE:
  - If any REQ_VALID is set, pick the first set bit searching from pointer+1 upward, with modulo N_REQ wrap.
  - Register ADDRESS_REQ, WE and DATA_W from the chosen slice, store owner = index, set DO_ACT=1, go to ISSUE.
  - If no request is pending, stay in IDLE with DO_ACT=0.
  - Arbitration takes 1 cycle from REQ_VALID sampled to DO_ACT high.
- ISSUE:
  - ADDRESS_REQ, WE, DATA_W and owner are held stable; client inputs are ignored.
  - On the cycle COMMAND_LATCHED=1, REQ_GRANT[owner] is driven combinationally high for that cycle only. On the next edge: DO_ACT<=0, pointer<=owner, FSM<=IDLE.
  - A client samples REQ_GRANT and must deassert or advance its REQ_VALID in the following cycle. A REQ_VALID still high on that cycle is treated as a new request.
  - COMMAND_LATCHED while in IDLE is ignored: no grant and no tag.
- Back-to-back accesses:
  - Minimum spacing is latch, IDLE, DO_ACT. This matches enter_state's single-command-per-DO_ACT behaviour.
- Fairness:
  - A continuously requesting client is granted at most once per N_REQ grants while others are requesting.
  - Clients with REQ_VALID=0 are skipped with no lost cycle.
- Read return:
  - Shift pipeline of READ_LATENCY entries, each holding {valid, owner id}.
  - On a latch with WE=0, a valid tag enters at stage 0. On a latch with WE=1, or with no latch, an invalid tag enters.
  - When a tag reaches the pipeline output (READ_LATENCY cycles after the latch cycle), RD_VALID[id] is high for 1 cycle and RD_DATA=DATA_R sampled in that cycle.
  - RD_DATA holds its last value otherwise.
  - Reads in flight complete even while new requests are arbitrated. Pipeline slots never collide because latches are at least 2 cycles apart.
- Writes: fire-and-forget; REQ_GRANT is the only completion indication.
- Refresh:
  - Free-running counter, 0..REFRESH_PERIOD-1, wraps to 0.
  - At wrap, REFRESH_STROBE toggles. It runs independently of the FSM; enter_state inserts the refresh between accesses.
  - A refresh may delay COMMAND_LATCHED arbitrarily; DO_ACT is simply held.
- Reset mid-operation:
  - Any ISSUE is abandoned with no grant.
  - In-flight read tags are discarded and no RD_VALID is produced.

Test Plan:
- Single write: client 2 writes addr 0x0001234, data 0xDEADBEEF. Required: DO_ACT rises 1 cycle after REQ_VALID; ADDRESS_REQ and DATA_W carry those values; REQ_GRANT=4'b0100 in exactly the COMMAND_LATCHED cycle; DO_ACT=0 the next cycle; no RD_VALID.
- Read return: client 1 reads; the model returns DATA_R=0xA5A5_0001 exactly 4 cycles after the latch. Required: RD_VALID=4'b0010 for one cycle, RD_DATA=0xA5A50001.
- Round-robin: all four clients hold REQ_VALID continuously after reset. Required: grant order 0,1,2,3,0,1; no client is granted twice in a row.
- Skipping and interleaving:
  - Clients 0 and 3 request. Required: grants 0,3,0,3.
  - Interleaved reads to 0 and 3. Required: RD_VALID order matches grant order, each exactly 4 cycles after its latch.
- Refresh: REFRESH_PERIOD=8, idle. Required: REFRESH_STROBE toggles at cycles 8, 16 and 24 after reset release.
- Reset mid-operation: assert RST while in ISSUE with a read tag in flight. Required:
  - DO_ACT=0 immediately, without waiting for a clock edge.
  - No REQ_GRANT and no RD_VALID afterwards.
  - After release, the first grant goes to client 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Client request/return bus and the shared DDR command path of mem_port_arbiter.
// master = arbiter side, slave = clients plus enter_state/outputs side.
interface mem_port_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]    REQ_VALID;
  logic [27*N_REQ-1:0] REQ_ADDR;
  logic [N_REQ-1:0]    REQ_WE;
  logic [32*N_REQ-1:0] REQ_DATA;
  logic [N_REQ-1:0]    REQ_GRANT;
  logic [N_REQ-1:0]    RD_VALID;
  logic [31:0]         RD_DATA;
  logic [26:0]         ADDRESS_REQ;
  logic                WE;
  logic [31:0]         DATA_W;
  logic                DO_ACT;
  logic                COMMAND_LATCHED;
  logic [31:0]         DATA_R;
  logic                REFRESH_STROBE;

  modport master (
    input  REQ_VALID, REQ_ADDR, REQ_WE, REQ_DATA, COMMAND_LATCHED, DATA_R,
    output REQ_GRANT, RD_VALID, RD_DATA, ADDRESS_REQ, WE, DATA_W, DO_ACT, REFRESH_STROBE
  );

  modport slave (
    output REQ_VALID, REQ_ADDR, REQ_WE, REQ_DATA, COMMAND_LATCHED, DATA_R,
    input  REQ_GRANT, RD_VALID, RD_DATA, ADDRESS_REQ, WE, DATA_W, DO_ACT, REFRESH_STROBE
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of the single DDR command path between N_REQ clients,
// with read-return tagging and a free-running toggle-type refresh strobe.
module mem_port_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned READ_LATENCY   = 4,
  parameter int unsigned REFRESH_PERIOD = 1560
) (
  input  logic               CLK,
  input  logic               RST,
  mem_port_arbiter_if.master bus
);
  localparam int unsigned AW    = 27;
  localparam int unsigned DW    = 32;
  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(REFRESH_PERIOD);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                  state_q;
  logic [ID_W-1:0]         owner_q;
  logic [ID_W-1:0]         ptr_q;
  logic [AW-1:0]           addr_q;
  logic                    we_q;
  logic [DW-1:0]           wdata_q;
  logic                    do_act_q;
  logic [READ_LATENCY-1:0] tag_vld_q;
  logic [ID_W-1:0]         tag_id_q [READ_LATENCY];
  logic [DW-1:0]           rd_data_q;
  logic [CNT_W-1:0]        ref_cnt_q;
  logic                    ref_q;

  logic            pick_vld;
  logic [ID_W-1:0] pick_idx;
  logic [ID_W-1:0] cand;
  logic [AW-1:0]   pick_addr;
  logic [DW-1:0]   pick_data;
  logic            pick_we;
  logic            latch_c;
  logic            rd_out_c;

  // First pending client strictly after the last owner, wrapping modulo N_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(ptr_q) + k) % N_REQ);
      if (!pick_vld && bus.REQ_VALID[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    pick_addr = '0;
    pick_data = '0;
    pick_we   = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == pick_idx) begin
        pick_addr = bus.REQ_ADDR[AW*i +: AW];
        pick_data = bus.REQ_DATA[DW*i +: DW];
        pick_we   = bus.REQ_WE[i];
      end
    end
  end

  assign latch_c  = (state_q == ISSUE) && bus.COMMAND_LATCHED;
  assign rd_out_c = tag_vld_q[READ_LATENCY-1];

  assign bus.REQ_GRANT      = latch_c ? (N_REQ'(1) << owner_q) : '0;
  assign bus.RD_VALID       = rd_out_c ? (N_REQ'(1) << tag_id_q[READ_LATENCY-1]) : '0;
  // Returned word is passed through in its tag cycle and held afterwards.
  assign bus.RD_DATA        = rd_out_c ? bus.DATA_R : rd_data_q;
  assign bus.ADDRESS_REQ    = addr_q;
  assign bus.WE             = we_q;
  assign bus.DATA_W         = wdata_q;
  assign bus.DO_ACT         = do_act_q;
  assign bus.REFRESH_STROBE = ref_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= ID_W'(N_REQ - 1);
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      do_act_q  <= 1'b0;
      tag_vld_q <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) tag_id_q[i] <= '0;
      rd_data_q <= '0;
      ref_cnt_q <= '0;
      ref_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            owner_q  <= pick_idx;
            addr_q   <= pick_addr;
            we_q     <= pick_we;
            wdata_q  <= pick_data;
            do_act_q <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.COMMAND_LATCHED) begin
            do_act_q <= 1'b0;
            ptr_q    <= owner_q;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Only latched reads carry a valid tag down the return pipeline.
      tag_vld_q[0] <= latch_c & ~we_q;
      tag_id_q[0]  <= owner_q;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      if (rd_out_c) rd_data_q <= bus.DATA_R;

      if (ref_cnt_q == CNT_W'(REFRESH_PERIOD - 1)) begin
        ref_cnt_q <= '0;
        ref_q     <= ~ref_q;
      end else begin
        ref_cnt_q <= ref_cnt_q + CNT_W'(1);
      end
    end
  end
endmodule
